// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and types for the UART command sequencer:
//               ALU opcodes, flag bit positions, the sequencer state encoding
//               and the default UART bit period.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // 100 MHz system clock / 115200 baud
  localparam int c_CLK_PER_BIT = 868;

  // Opcode byte values
  localparam logic [7:0] OP_ADD = 8'h0A;
  localparam logic [7:0] OP_SUB = 8'h0B;
  localparam logic [7:0] OP_AND = 8'h0C;
  localparam logic [7:0] OP_OR  = 8'h0D;

  // Bit positions inside the flags byte
  localparam int c_FLG_CARRY = 0;
  localparam int c_FLG_ZERO  = 1;
  localparam int c_FLG_BADOP = 7;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_B    = 3'd1,
    S_GET_OP   = 3'd2,
    S_EXEC     = 3'd3,
    S_SEND_RES = 3'd4,
    S_WAIT_RES = 3'd5,
    S_SEND_FLG = 3'd6,
    S_WAIT_FLG = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_alu.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_alu
// Description : Combinational 8-bit unsigned ALU for the command sequencer.
//               Produces the result byte and the flags byte for one opcode.
// Ports       : i_op     - opcode byte
//               i_a/i_b  - operands
//               o_result - ALU result (0x00 for an unknown opcode)
//               o_flags  - bit0 carry/borrow, bit1 zero, bit7 bad opcode
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_alu
  import uart_pkg::*;
(
  input  logic [7:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_result,
  output logic [7:0] o_flags
);

  logic [8:0] w_sum;
  logic [7:0] w_result;
  logic [7:0] w_flags;

  always_comb begin
    w_sum    = 9'd0;
    w_result = 8'h00;
    w_flags  = 8'h00;
    case (i_op)
      OP_ADD: begin
        w_sum                = {1'b0, i_a} + {1'b0, i_b};
        w_result             = w_sum[7:0];
        w_flags[c_FLG_CARRY] = w_sum[8];
      end
      OP_SUB: begin
        w_result             = i_a - i_b;
        w_flags[c_FLG_CARRY] = (i_a < i_b);
      end
      OP_AND:  w_result = i_a & i_b;
      OP_OR:   w_result = i_a | i_b;
      default: w_flags[c_FLG_BADOP] = 1'b1;
    endcase
    // A bad opcode reports only the bad-opcode bit, never zero.
    if (!w_flags[c_FLG_BADOP]) begin
      w_flags[c_FLG_ZERO] = (w_result == 8'h00);
    end
  end

  assign o_result = w_result;
  assign o_flags  = w_flags;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_sequencer
// Description : Collects a 3-byte command (A, B, opcode) from the UART RX
//               byte stream, executes it on the ALU and sends the result and
//               flags bytes to the UART TX with a start/busy handshake.
// Ports       : clk, res              - clock, synchronous active-high reset
//               i_en                  - enable; low returns to IDLE
//               i_rx_data/valid/perr  - received byte, strobe, frame error
//               o_tx_data/o_tx_start  - byte to send and one-cycle request
//               i_tx_busy             - transmitter busy
//               o_result/o_flags      - last ALU result and flags
//               o_cmd_done/o_cmd_err  - completion / abort pulses
//               o_rx_drop             - byte ignored while not accepting
//               o_busy                - high outside IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_sequencer
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = c_CLK_PER_BIT,
  parameter int TIMEOUT     = 22 * CLK_PER_BIT,
  parameter int TO_W        = 15
) (
  input  logic       clk,
  input  logic       res,
  input  logic       i_en,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  input  logic       i_rx_perr,
  output logic [7:0] o_tx_data,
  output logic       o_tx_start,
  input  logic       i_tx_busy,
  output logic [7:0] o_result,
  output logic [7:0] o_flags,
  output logic       o_cmd_done,
  output logic       o_cmd_err,
  output logic       o_rx_drop,
  output logic       o_busy
);

  localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          r_state;
  logic [7:0]      r_op_a;
  logic [7:0]      r_op_b;
  logic [7:0]      r_opcode;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_guard;
  logic [7:0]      r_tx_data;
  logic            r_tx_start;
  logic [7:0]      r_result;
  logic [7:0]      r_flags;
  logic            r_cmd_done;
  logic            r_cmd_err;
  logic            r_rx_drop;

  logic [7:0]      w_alu_result;
  logic [7:0]      w_alu_flags;
  logic            w_accepting;

  uart_cmd_alu u_alu (
    .i_op     (r_opcode),
    .i_a      (r_op_a),
    .i_b      (r_op_b),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  assign w_accepting = (r_state == S_IDLE) || (r_state == S_GET_B) ||
                       (r_state == S_GET_OP);

  always_ff @(posedge clk) begin
    if (res) begin
      r_state    <= S_IDLE;
      r_op_a     <= 8'h00;
      r_op_b     <= 8'h00;
      r_opcode   <= 8'h00;
      r_to_cnt   <= '0;
      r_guard    <= 1'b0;
      r_tx_data  <= 8'h00;
      r_tx_start <= 1'b0;
      r_result   <= 8'h00;
      r_flags    <= 8'h00;
      r_cmd_done <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_rx_drop  <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_cmd_done <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_rx_drop  <= i_en && i_rx_valid && !w_accepting;

      case (r_state)
        S_IDLE: begin
          r_to_cnt <= '0;
          if (i_en && i_rx_valid) begin
            if (i_rx_perr) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_op_a  <= i_rx_data;
              r_state <= S_GET_B;
            end
          end
        end

        S_GET_B, S_GET_OP: begin
          if (!i_en) begin
            r_to_cnt <= '0;
            r_state  <= S_IDLE;
          end else if (i_rx_valid) begin
            // A byte arriving on the expiry cycle wins over the timeout.
            r_to_cnt <= '0;
            if (i_rx_perr) begin
              r_cmd_err <= 1'b1;
              r_state   <= S_IDLE;
            end else if (r_state == S_GET_B) begin
              r_op_b  <= i_rx_data;
              r_state <= S_GET_OP;
            end else begin
              r_opcode <= i_rx_data;
              r_state  <= S_EXEC;
            end
          end else if (r_to_cnt == c_TO_LAST) begin
            r_to_cnt  <= '0;
            r_cmd_err <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        S_EXEC: begin
          if (!i_en) begin
            r_state <= S_IDLE;
          end else begin
            r_result   <= w_alu_result;
            r_flags    <= w_alu_flags;
            r_tx_data  <= w_alu_result;
            r_tx_start <= 1'b1;
            r_state    <= S_SEND_RES;
          end
        end

        S_SEND_RES: begin
          r_guard <= 1'b1;
          r_state <= S_WAIT_RES;
        end

        S_WAIT_RES: begin
          // First WAIT cycle skips tx_busy: the transmitter may take a
          // cycle to raise it after tx_start.
          if (r_guard) begin
            r_guard <= 1'b0;
          end else if (!i_tx_busy) begin
            if (i_en) begin
              r_tx_data  <= r_flags;
              r_tx_start <= 1'b1;
              r_state    <= S_SEND_FLG;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        S_SEND_FLG: begin
          r_guard <= 1'b1;
          r_state <= S_WAIT_FLG;
        end

        S_WAIT_FLG: begin
          if (r_guard) begin
            r_guard <= 1'b0;
          end else if (!i_tx_busy) begin
            r_cmd_done <= i_en;
            r_state    <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_start = r_tx_start;
  assign o_result   = r_result;
  assign o_flags    = r_flags;
  assign o_cmd_done = r_cmd_done;
  assign o_cmd_err  = r_cmd_err;
  assign o_rx_drop  = r_rx_drop;
  assign o_busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Command controller between the UART receiver and the UART transmitter.
- Collects a 3-byte command from the RX byte stream: operand A, operand B, then opcode. Bytes arrive as 11-bit frames: start, 8 data LSB-first, even parity, stop.
- Executes ADD/SUB/AND/OR on an internal 8-bit ALU.
- Sequences a 2-byte response (result, flags) into the transmitter with a start/busy handshake. Discards malformed commands and stalled commands.

Parameters:
- CLK_PER_BIT, 868, clocks per UART bit (100 MHz / 115200).
- TIMEOUT, 19096, max clocks between command bytes (two frames at 11 bits × CLK_PER_BIT).
- TO_W, 15, width of the timeout counter.

Ports:
- clk  in  1  system clock, 100 MHz
- res  in  1  synchronous reset, active-high
- en  in  1  sequencer enable; low forces IDLE and ignores RX
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data/rx_perr valid
- rx_perr  in  1  parity or stop-bit error on this byte
- tx_data  out  8  byte to transmit, held stable from tx_start until tx_busy falls
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy; rises no later than 1 cycle after tx_start
- result  out  8  last ALU result, held
- flags  out  8  bit0 carry/borrow, bit1 zero, bit7 bad opcode, others 0
- cmd_done  out  1  one-cycle pulse when the flags byte finishes transmitting
- cmd_err  out  1  one-cycle pulse on parity error or timeout abort
- rx_drop  out  1  one-cycle pulse when rx_valid arrives while not accepting
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (res=1 at a clk edge) moves to IDLE. All outputs go to 0; op_a, op_b, the timeout counter and the guard flag clear. Reset mid-transmit abandons the response; no tx_start is reissued.
- States and transitions:
  - IDLE: on rx_valid, latch A and go to GET_B.
  - GET_B: on rx_valid, latch B and go to GET_OP.
  - GET_OP: on rx_valid, latch the opcode and go to EXEC.
  - EXEC: one cycle, computes result/flags, then SEND_RES.
  - SEND_RES: pulse tx_start with tx_data=result, go to WAIT_RES.
  - WAIT_RES: wait for tx_busy low, then SEND_FLG.
  - SEND_FLG: pulse tx_start with tx_data=flags, go to WAIT_FLG.
  - WAIT_FLG: wait for tx_busy low, then pulse cmd_done and return to IDLE.
- WAIT_* guard: tx_busy is not sampled in the first cycle of a WAIT state. From the second cycle on, tx_busy=0 advances the state.
- Parity error: rx_valid with rx_perr=1 in IDLE, GET_B or GET_OP drops the whole command. Pulse cmd_err and go to IDLE; nothing is transmitted.
- Timeout:
  - The counter resets on each accepted byte and counts only in GET_B and GET_OP.
  - Reaching TIMEOUT-1 pulses cmd_err and returns to IDLE.
  - If rx_valid arrives in the same cycle the timeout expires, the byte is accepted and there is no abort.
- rx_valid in EXEC, SEND_* or WAIT_* pulses rx_drop; the byte is ignored and the state is unaffected.
- en=0: when not transmitting, go to IDLE with no pulses. While in SEND_*/WAIT_*, finish the current byte handshake, then go to IDLE without sending the next byte; cmd_done is not pulsed.
- ALU, registered in EXEC, 8-bit unsigned:
  - 0x0A ADD: {carry,result}=A+B.
  - 0x0B SUB: result=A-B; borrow=1 when A<B.
  - 0x0C AND: result=A&B; carry=0.
  - 0x0D OR: result=A|B; carry=0.
  - Any other opcode: result=0x00, flags=0x80.
- zero flag = (result==0), valid opcodes only.
- Latency: from the opcode byte's rx_valid cycle to the first tx_start is 2 cycles.

Decomposition:
- Shared package uart_pkg holds:
  - opcode constants OP_ADD=0x0A, OP_SUB=0x0B, OP_AND=0x0C, OP_OR=0x0D
  - flag bit indices
  - state encoding, 3 bits, 8 states
  - CLK_PER_BIT default
- One sub-module, uart_cmd_alu: combinational op/A/B to result/flags. The sequencer registers its output in EXEC.

Test Plan:
- ADD: bytes 0x0F, 0x0E, 0x0A → tx bytes 0x1D then 0x00; result=0x1D; one cmd_done.
- Full opcode sweep, each with a stub transmitter (busy 50 cycles):
  - SUB 0x0F,0x0E,0x0B → 0x01, 0x00
  - SUB 0x0E,0x0F,0x0B → 0xFF, 0x01
  - AND 0x0F,0x0E,0x0C → 0x0E, 0x00
  - OR 0x0F,0x0E,0x0D → 0x0F, 0x00
  - ADD 0xFF,0x01,0x0A → 0x00, 0x03
- Bad opcode 0x20 → tx 0x00, 0x80. Parity error on the opcode byte → cmd_err pulse, no tx_start; the following valid ADD command completes normally.
- Timeout: send A and B, then idle TIMEOUT cycles → cmd_err at cycle TIMEOUT-1, state IDLE. rx_valid on exactly that cycle → no abort.
- rx_valid during WAIT_RES → rx_drop pulse, response bytes unchanged. Reset asserted during WAIT_FLG → all outputs 0 next cycle, no further tx_start.
- en=0 during GET_OP → IDLE, no pulses. Back-to-back commands, each A byte given 1 cycle after cmd_done → both responses correct.
